// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB phase control with memory handshake.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module cycle_sequencer #(
   parameter logic [4:0] HALT_OPCODE = 5'b11111,
   parameter int         CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [4:0]       OPCODE,
   input  logic             MemReadIn,
   input  logic             MemWriteIn,
   input  logic [5:0]       WriteEnIn,
   input  logic             MemReady,
   output logic             MemReq,
   output logic             MemReadOut,
   output logic             MemWriteOut,
   output logic             IRWrite,
   output logic             PCIncr,
   output logic [5:0]       WriteEnOut,
   output logic [2:0]       State,
   output logic             Halted,
   output logic [CNT_W-1:0] InstrCount
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'b000,
      S_DECODE = 3'b001,
      S_EXEC   = 3'b010,
      S_MEM    = 3'b011,
      S_WB     = 3'b100,
      S_HALT   = 3'b111
   } state_t;

   state_t state_q, state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (MemReady) state_d = S_DECODE;
         S_DECODE: state_d = (OPCODE == HALT_OPCODE) ? S_HALT : S_EXEC;
         S_EXEC:   state_d = (MemReadIn || MemWriteIn) ? S_MEM : S_WB;
         S_MEM:    if (MemReady) state_d = S_WB;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Strobes depend on the live handshake and control inputs, so they are decoded
   // combinationally; Reset forces every one of them low immediately.
   always_comb begin
      MemReq      = 1'b0;
      MemReadOut  = 1'b0;
      MemWriteOut = 1'b0;
      IRWrite     = 1'b0;
      PCIncr      = 1'b0;
      WriteEnOut  = 6'b000000;
      Halted      = 1'b0;
      if (!Reset) begin
         case (state_q)
            S_FETCH: begin
               MemReq     = 1'b1;
               MemReadOut = 1'b1;
               IRWrite    = MemReady;
               PCIncr     = MemReady;
            end
            S_MEM: begin
               MemReq      = 1'b1;
               MemReadOut  = MemReadIn;
               MemWriteOut = MemWriteIn;
            end
            S_WB:    WriteEnOut = WriteEnIn;
            S_HALT:  Halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign State = state_q;

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_WB) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge CLK) begin
      if (Reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign InstrCount = cnt_q;
`else
   assign InstrCount = '0;
`endif

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter HALT_OPCODE, default 5'b11111, opcode that stops sequencing.
REQ-002 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, synchronous and active-high.
REQ-005 OPCODE  input  5  opcode field of the instruction register.
REQ-006 MemReadIn  input  1  MemRead from control_unit for the current opcode.
REQ-007 MemWriteIn  input  1  MemWrite from control_unit for the current opcode.
REQ-008 WriteEnIn  input  6  control_unit enables {MaryWrite, ShelleyWrite, CompWrite, RAWrite, PCWrite, SPWrite}.
REQ-009 MemReady  input  1  memory acknowledge; completes the current MemReq transfer.
REQ-010 MemReq  output  1  memory transfer request.
REQ-011 MemReadOut  output  1  read qualifier for MemReq.
REQ-012 MemWriteOut  output  1  write qualifier for MemReq.
REQ-013 IRWrite  output  1  instruction-register load strobe.
REQ-014 PCIncr  output  1  PC+1 strobe.
REQ-015 WriteEnOut  output  6  gated register enables, same bit order as WriteEnIn.
REQ-016 State  output  3  current phase: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, HALT=111.
REQ-017 Halted  output  1  high while in HALT.
REQ-018 InstrCount  output  CNT_W  retired-instruction count (see Configuration).

Function
REQ-019 FETCH: MemReq=1, MemReadOut=1; stay until MemReady=1; in that cycle IRWrite=1 and PCIncr=1 (one-cycle pulses), next state DECODE.
REQ-020 DECODE: one cycle; next state HALT if OPCODE==HALT_OPCODE, else EXEC.
REQ-021 EXEC: one cycle; next state MEM if MemReadIn|MemWriteIn, else WB.
REQ-022 MEM: MemReq=1, MemReadOut=MemReadIn, MemWriteOut=MemWriteIn; hold all three stable until MemReady=1; then next state WB.
REQ-023 WB: WriteEnOut=WriteEnIn for exactly one cycle; next state FETCH; instruction counts as retired.
REQ-024 WriteEnOut=0 in every state other than WB; IRWrite, PCIncr=0 outside FETCH-completion cycle.
REQ-025 MemReq, MemReadOut, MemWriteOut=0 in DECODE, EXEC, WB, HALT.
REQ-026 MemReady while MemReq=0 is ignored; no state change.
REQ-027 MemReady held high continuously: zero-wait transfers; FETCH and MEM each last one cycle.
REQ-028 Latency with zero-wait memory: non-memory instruction 4 cycles, memory instruction 5 cycles, FETCH to FETCH; each wait cycle adds one.
REQ-029 HALT is absorbing; exit only via Reset; all strobes and MemReq=0 in HALT.
REQ-030 OPCODE, MemReadIn, MemWriteIn, WriteEnIn are sampled combinationally; no internal latching.

Reset
REQ-031 Reset=1 at a rising edge forces State=FETCH and InstrCount=0 at that edge, overriding any other transition.
REQ-032 While Reset=1, all outputs other than State are 0 (MemReq, IRWrite, PCIncr, WriteEnOut, Halted, qualifiers).
REQ-033 Reset mid-transfer (FETCH or MEM with MemReq=1) abandons the transfer; no IRWrite, PCIncr, or WriteEnOut pulse results.
REQ-034 First cycle after Reset deasserts: State=FETCH, MemReq=1.

Configuration
REQ-035 Macro SEQ_PERF_CNT_EN defined: InstrCount increments by 1 at each WB cycle, wraps from 2^CNT_W-1 to 0; absent: InstrCount tied to 0, no counter register.

Verification
REQ-036 Reset, OPCODE=5'b00010 (AADD), MemReady=1, WriteEnIn=6'b100000 -> States 000,001,010,100,000; WriteEnOut=6'b100000 only in WB cycle.
REQ-037 OPCODE=5'b10011 (LOAD), MemReadIn=1, MemReady low 3 cycles in MEM -> MEM held 4 cycles, MemReq/MemReadOut stable, then WB.
REQ-038 OPCODE=5'b10101 (BKAC), MemWriteIn=1, MemReady=1 -> MemWriteOut=1 for one MEM cycle; 5-cycle instruction.
REQ-039 OPCODE=5'b11111 -> DECODE then HALT, Halted=1, MemReq=0 for 20 cycles with MemReady toggling; Reset -> FETCH.
REQ-040 Reset asserted during MEM with MemReady=0 -> next State=000, no WriteEnOut pulse, InstrCount=0.
REQ-041 SEQ_PERF_CNT_EN, CNT_W=4, 17 back-to-back AADD -> InstrCount reads 0x1 after wrap; without macro reads 0 throughout.
